fetch_predict: RTL and testbench

Parametrised instruction-fetch stage with a selectable branch predictor. It generalises the core's fixed "always predict taken" fetch logic to three modes: static-taken, static-not-taken, and a bimodal table of 2-bit counters with a configurable number of entries. It sits between the synchronous instruction memory and decode. It drives the memory address every cycle, tracks the PC of the returned instruction, and accepts redirect and training information from branch resolution in decode.

---
 rtl/fetch_predict.sv | 142 ++++++++++++++
 tb/tb_fetch_predict.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict.sv
// Instruction-fetch stage with static-taken, static-not-taken or bimodal branch prediction.
// Drives a one-cycle-latency instruction memory and tracks the PC of the returned word.
module fetch_predict #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       BHT_ENTRIES = 64,
  parameter int unsigned       PRED_MODE   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [31:0]       instr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_alt,
  input  logic              jalr_valid,
  input  logic [ADDR_W-1:0] jalr_target,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic              resolve_taken,
  input  logic              resolve_mispredict,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count
);

  localparam int unsigned IDX_W    = $clog2(BHT_ENTRIES);
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpBranch = 7'b1100011;

  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [31:0]       branch_count_q;
  logic [31:0]       mispredict_count_q;

  logic              is_jal;
  logic              is_branch;
  logic signed [20:0] jal_off;
  logic signed [12:0] br_off;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jal_tgt;
  logic [ADDR_W-1:0] br_tgt;
  logic              dir_taken;
  logic              update_en;

  assign is_jal    = (instr[6:0] == OpJal);
  assign is_branch = (instr[6:0] == OpBranch);
  assign jal_off   = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign br_off    = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  // Signed size casts sign-extend the offsets to the address width.
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign jal_tgt  = pc_q + ADDR_W'(jal_off);
  assign br_tgt   = pc_q + ADDR_W'(br_off);

  assign update_en = resolve_valid && !stall;

  if (PRED_MODE == 2) begin : g_bht
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_resolve;

    assign rd_idx         = pc_q[IDX_W+1:2];
    assign wr_idx         = resolve_pc[IDX_W+1:2];
    assign unused_resolve = ^resolve_pc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
          bht_q[i] <= 2'b01;
        end
      end else if (update_en) begin
        if (resolve_taken && (bht_q[wr_idx] != 2'b11)) begin
          bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
        end else if (!resolve_taken && (bht_q[wr_idx] != 2'b00)) begin
          bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
        end
      end
    end

    assign dir_taken = bht_q[rd_idx][1];
  end else begin : g_static
    logic unused_resolve;

    assign unused_resolve = ^{resolve_pc, resolve_taken};
    assign dir_taken      = (PRED_MODE == 0);
  end

  assign pred_taken = valid_q && is_branch && dir_taken;

  always_comb begin
    imem_addr = pc_q;
    if (stall) begin
      imem_addr = pc_q;
    end else if (resolve_valid && resolve_mispredict) begin
      imem_addr = resolve_target;
    end else if (jalr_valid) begin
      imem_addr = jalr_target;
    end else if (valid_q && is_jal) begin
      imem_addr = jal_tgt;
    end else if (pred_taken) begin
      imem_addr = br_tgt;
    end else if (valid_q) begin
      imem_addr = pc_plus4;
    end else begin
      // No word has been returned yet, so the reset PC itself is the first fetch.
      imem_addr = pc_q;
    end
  end

  always_comb begin
    pred_alt = pc_plus4;
    if (valid_q && is_branch && !pred_taken) begin
      pred_alt = br_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      valid_q            <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (!stall) begin
      pc_q    <= imem_addr;
      valid_q <= 1'b1;
      if (resolve_valid) begin
        branch_count_q     <= branch_count_q + 32'd1;
        mispredict_count_q <= mispredict_count_q + 32'(resolve_mispredict);
      end
    end
  end

  assign instr_pc         = pc_q;
  assign instr_valid      = valid_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: one bimodal instance plus static-taken and
// static-not-taken instances sharing the same stimulus.
module tb_fetch_predict;

  localparam logic [31:0] Nop = 32'h0000_0013;
  localparam logic [31:0] Jal = 32'h0100_006F;  // jal x0, +16
  localparam logic [31:0] Br  = 32'hFE00_0CE3;  // beq x0, x0, -8

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr = Nop;
  logic        jalr_valid = 1'b0;
  logic [31:0] jalr_target = '0;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic        resolve_mispredict = 1'b0;
  logic [31:0] resolve_target = '0;

  logic [31:0] imem2, pc2, alt2, bc2, mc2;
  logic        valid2, pt2;
  logic [31:0] imem0, pc0, alt0, bc0, mc0;
  logic        valid0, pt0;
  logic [31:0] imem1, pc1, alt1, bc1, mc1;
  logic        valid1, pt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_predict #(.PRED_MODE(2)) u_bim (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr),
    .imem_addr(imem2), .instr_pc(pc2), .instr_valid(valid2),
    .pred_taken(pt2), .pred_alt(alt2),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .resolve_target(resolve_target),
    .branch_count(bc2), .mispredict_count(mc2)
  );

  fetch_predict #(.PRED_MODE(0)) u_taken (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr),
    .imem_addr(imem0), .instr_pc(pc0), .instr_valid(valid0),
    .pred_taken(pt0), .pred_alt(alt0),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .resolve_target(resolve_target),
    .branch_count(bc0), .mispredict_count(mc0)
  );

  fetch_predict #(.PRED_MODE(1)) u_ntaken (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr),
    .imem_addr(imem1), .instr_pc(pc1), .instr_valid(valid1),
    .pred_taken(pt1), .pred_alt(alt1),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
    .resolve_target(resolve_target),
    .branch_count(bc1), .mispredict_count(mc1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] train_tk;
  logic [6:0] train_pt;

  initial begin
    // Reset asserted before any clock edge: state must clear asynchronously.
    #2 rst = 1'b1;
    #1;
    check("rst_imem", imem2, 32'h0);
    check("rst_valid", 32'(valid2), 32'd0);
    check("rst_pred", 32'(pt2), 32'd0);
    check("rst_alt", alt2, 32'h4);
    check("rst_bc", bc2, 32'd0);
    check("rst_mc", mc2, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("seq_imem0", imem2, 32'h0);

    tick();
    check("seq_valid", 32'(valid2), 32'd1);
    check("seq_pc0", pc2, 32'h0);
    check("seq_imem4", imem2, 32'h4);
    check("seq_pred", 32'(pt2), 32'd0);
    tick();
    check("seq_imem8", imem2, 32'h8);
    tick();
    check("seq_imem12", imem2, 32'hC);

    instr = Jal;
    #1;
    check("jal_target", imem2, 32'h18);
    tick();
    instr = Nop;
    #1;
    check("jal_pc", pc2, 32'h18);
    check("jal_next", imem2, 32'h1C);

    // Hold a JALR to 0x40 so the branch stays at the same PC while training.
    jalr_valid  = 1'b1;
    jalr_target = 32'h40;
    #1;
    check("jalr_imem", imem2, 32'h40);
    tick();
    instr         = Br;
    resolve_valid = 1'b1;
    resolve_pc    = 32'h40;
    resolve_taken = 1'b1;
    #1;
    check("bht_init", 32'(pt2), 32'd0);
    check("bht_init_alt", alt2, 32'h38);
    check("static_t_pred", 32'(pt0), 32'd1);
    check("static_nt_pred", 32'(pt1), 32'd0);

    // Counter 01 -> 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00
    train_tk = 7'b0000111;
    train_pt = 7'b0001111;
    for (int k = 0; k < 7; k++) begin
      resolve_taken = train_tk[k];
      tick();
      check($sformatf("bht_train%0d", k), 32'(pt2), 32'(train_pt[k]));
      check($sformatf("bc_train%0d", k), bc2, 32'(k + 1));
      if (k == 1) check("bht_taken_alt", alt2, 32'h44);
    end
    check("mc_train", mc2, 32'd0);

    // Mispredict and JAL in the same cycle: redirect wins.
    jalr_valid         = 1'b0;
    instr              = Jal;
    resolve_taken      = 1'b0;
    resolve_mispredict = 1'b1;
    resolve_target     = 32'h100;
    #1;
    check("mis_jal_imem", imem2, 32'h100);
    tick();
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    instr              = Nop;
    #1;
    check("mis_mc", mc2, 32'd1);
    check("mis_bc", bc2, 32'd8);
    check("mis_pc", pc2, 32'h100);
    check("mis_next", imem2, 32'h104);

    // Stall with a pending redirect: nothing moves until release.
    stall              = 1'b1;
    resolve_valid      = 1'b1;
    resolve_pc         = 32'h40;
    resolve_taken      = 1'b1;
    resolve_mispredict = 1'b1;
    resolve_target     = 32'h200;
    #1;
    check("stall_imem", imem2, 32'h100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_pc%0d", k), pc2, 32'h100);
      check($sformatf("stall_imem%0d", k), imem2, 32'h100);
      check($sformatf("stall_bc%0d", k), bc2, 32'd8);
      check($sformatf("stall_mc%0d", k), mc2, 32'd1);
    end
    stall = 1'b0;
    #1;
    check("unstall_imem", imem2, 32'h200);
    tick();
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    jalr_valid         = 1'b1;
    jalr_target        = 32'h40;
    #1;
    check("unstall_bc", bc2, 32'd9);
    check("unstall_mc", mc2, 32'd2);
    check("unstall_pc", pc2, 32'h200);
    tick();
    // Exactly one update happened during the stall: counter is 01.
    instr         = Br;
    resolve_valid = 1'b1;
    resolve_taken = 1'b1;
    #1;
    check("stall_bht", 32'(pt2), 32'd0);
    tick();
    check("stall_bht_inc", 32'(pt2), 32'd1);
    check("stall_bht_bc", bc2, 32'd10);

    // Static modes on a branch at 0x20 with offset -8.
    resolve_valid = 1'b0;
    jalr_target   = 32'h20;
    instr         = Nop;
    tick();
    jalr_valid = 1'b0;
    instr      = Br;
    #1;
    check("st_t_imem", imem0, 32'h18);
    check("st_t_alt", alt0, 32'h24);
    check("st_t_pred", 32'(pt0), 32'd1);
    check("st_nt_imem", imem1, 32'h24);
    check("st_nt_alt", alt1, 32'h18);
    check("st_nt_pred", 32'(pt1), 32'd0);

    // PC wrap at the top of the address space.
    jalr_valid  = 1'b1;
    jalr_target = 32'hFFFF_FFFC;
    instr       = Nop;
    tick();
    jalr_valid = 1'b0;
    #1;
    check("wrap_imem", imem2, 32'h0);
    tick();
    check("wrap_pc", pc2, 32'h0);

    // Asynchronous reset in the middle of a redirect cycle.
    resolve_valid      = 1'b1;
    resolve_mispredict = 1'b1;
    resolve_target     = 32'h300;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_pc", pc2, 32'h0);
    check("mid_rst_valid", 32'(valid2), 32'd0);
    check("mid_rst_bc", bc2, 32'd0);
    check("mid_rst_mc", mc2, 32'd0);
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    #1;
    check("mid_rst_imem", imem2, 32'h0);
    rst         = 1'b0;
    jalr_valid  = 1'b1;
    jalr_target = 32'h40;
    tick();
    jalr_valid = 1'b0;
    instr      = Br;
    #1;
    // Entry for 0x40 was 10 before reset; reset returns it to 01.
    check("bht_reset", 32'(pt2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
